// File: rtl/csr_unit_v2_if.sv
// Request/response bundle between the execute stage (master) and the CSR unit (slave).
interface csr_unit_v2_if #(
  parameter int unsigned XLEN = 64
);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      op;
  logic [2:0]      func3;
  logic [11:0]     csr_addr;
  logic [XLEN-1:0] rs1_val;
  logic [4:0]      zimm;
  logic [XLEN-1:0] pc;
  logic [4:0]      rd_a;
  logic            rd_w;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] rd_o;
  logic [4:0]      rd_a_o;
  logic            rd_w_o;
  logic            redirect;
  logic [XLEN-1:0] redirect_addr;

  modport master (
    output in_valid, op, func3, csr_addr, rs1_val, zimm, pc, rd_a, rd_w, out_ready,
    input  in_ready, out_valid, rd_o, rd_a_o, rd_w_o, redirect, redirect_addr
  );

  modport slave (
    input  in_valid, op, func3, csr_addr, rs1_val, zimm, pc, rd_a, rd_w, out_ready,
    output in_ready, out_valid, rd_o, rd_a_o, rd_w_o, redirect, redirect_addr
  );
endinterface

// File: rtl/csr_unit_v2.sv
// Machine-mode CSR unit: CSR read/modify/write, ECALL/EBREAK/MRET, timer interrupt.
// Requests are accepted in IDLE; the registered response is held in RESP until out_ready.
module csr_unit_v2 #(
  parameter int unsigned     XLEN         = 64,
  parameter logic [XLEN-1:0] MSTATUS_RST  = 'ha00001800,
  parameter logic [XLEN-1:0] MTVEC_RST    = '0,
  parameter bit              HAS_COUNTERS = 1'b1
) (
  input logic          clk,
  input logic          rst_n,
  input logic          retire,
  input logic          irq_timer,
  csr_unit_v2_if.slave bus
);
  typedef enum logic [2:0] {
    OP_NOP    = 3'd0,
    OP_CSR    = 3'd1,
    OP_ECALL  = 3'd2,
    OP_EBREAK = 3'd3,
    OP_MRET   = 3'd4
  } op_e;

  typedef enum logic {S_IDLE, S_RESP} state_e;

  localparam int unsigned MIE_BIT  = 3;
  localparam int unsigned MPIE_BIT = 7;
  localparam int unsigned MTIP_BIT = 7;

  state_e          state;
  logic [XLEN-1:0] mstatus, mie, mtvec, mscratch, mepc, mcause, mcycle, minstret;
  logic            in_ready_q, out_valid_q, rd_w_q, redirect_q;
  logic [XLEN-1:0] rd_q, redirect_addr_q;
  logic [4:0]      rd_a_q;

  logic [XLEN-1:0] src, old_val, new_val, mip, trap_cause;
  logic            known, read_only, f3_ok, do_write, illegal, irq_take, trap;

  assign mip      = XLEN'(irq_timer) << MTIP_BIT;
  assign src      = bus.func3[2] ? XLEN'(bus.zimm) : bus.rs1_val;
  assign f3_ok    = bus.func3[1:0] != 2'b00;
  // RS/RC with a zero source are pure reads, so they never count as a write.
  assign do_write = (bus.func3[1:0] == 2'b01) || (src != '0);
  assign irq_take = mstatus[MIE_BIT] & mie[MTIP_BIT] & irq_timer;
  assign trap     = irq_take | illegal | (bus.op == OP_ECALL) | (bus.op == OP_EBREAK);

  always_comb begin
    old_val   = '0;
    known     = 1'b1;
    read_only = 1'b0;
    case (bus.csr_addr)
      12'h300: old_val = mstatus;
      12'h304: old_val = mie;
      12'h305: old_val = mtvec;
      12'h340: old_val = mscratch;
      12'h341: old_val = mepc;
      12'h342: old_val = mcause;
      12'h344: begin old_val = mip; read_only = 1'b1; end
      12'hB00: begin old_val = HAS_COUNTERS ? mcycle : '0; read_only = !HAS_COUNTERS; end
      12'hB02: begin old_val = HAS_COUNTERS ? minstret : '0; read_only = !HAS_COUNTERS; end
      default: known = 1'b0;
    endcase
  end

  always_comb begin
    case (bus.func3[1:0])
      2'b01:   new_val = src;
      2'b10:   new_val = old_val | src;
      default: new_val = old_val & ~src;
    endcase
  end

  always_comb begin
    illegal = 1'b0;
    case (bus.op)
      OP_NOP, OP_ECALL, OP_EBREAK, OP_MRET: illegal = 1'b0;
      OP_CSR:  illegal = !known || !f3_ok || (do_write && read_only);
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    if (irq_take)                 trap_cause = {1'b1, (XLEN-1)'(7)};
    else if (illegal)             trap_cause = XLEN'(2);
    else if (bus.op == OP_ECALL)  trap_cause = XLEN'(11);
    else                          trap_cause = XLEN'(3);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      in_ready_q      <= 1'b1;
      out_valid_q     <= 1'b0;
      rd_q            <= '0;
      rd_a_q          <= '0;
      rd_w_q          <= 1'b0;
      redirect_q      <= 1'b0;
      redirect_addr_q <= '0;
      mstatus         <= MSTATUS_RST;
      mtvec           <= MTVEC_RST;
      mie             <= '0;
      mscratch        <= '0;
      mepc            <= '0;
      mcause          <= '0;
      mcycle          <= '0;
      minstret        <= '0;
    end else begin
      if (HAS_COUNTERS) begin
        mcycle <= mcycle + 1'b1;
        if (retire) minstret <= minstret + 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            state           <= S_RESP;
            in_ready_q      <= 1'b0;
            out_valid_q     <= 1'b1;
            rd_a_q          <= bus.rd_a;
            rd_q            <= '0;
            rd_w_q          <= 1'b0;
            redirect_q      <= 1'b0;
            redirect_addr_q <= '0;
            if (trap) begin
              mepc               <= {bus.pc[XLEN-1:2], 2'b00};
              mcause             <= trap_cause;
              mstatus[MPIE_BIT]  <= mstatus[MIE_BIT];
              mstatus[MIE_BIT]   <= 1'b0;
              mstatus[12:11]     <= 2'b11;
              redirect_q         <= 1'b1;
              redirect_addr_q    <= mtvec;
            end else if (bus.op == OP_MRET) begin
              mstatus[MIE_BIT]   <= mstatus[MPIE_BIT];
              mstatus[MPIE_BIT]  <= 1'b1;
              redirect_q         <= 1'b1;
              redirect_addr_q    <= mepc;
            end else if (bus.op == OP_CSR) begin
              rd_q   <= old_val;
              rd_w_q <= bus.rd_w;
              // Placed after the counter increment so a same-cycle write wins.
              if (do_write) begin
                case (bus.csr_addr)
                  12'h300: mstatus  <= new_val;
                  12'h304: mie      <= new_val & (XLEN'(1) << MTIP_BIT);
                  12'h305: mtvec    <= {new_val[XLEN-1:2], 2'b00};
                  12'h340: mscratch <= new_val;
                  12'h341: mepc     <= {new_val[XLEN-1:2], 2'b00};
                  12'h342: mcause   <= new_val;
                  12'hB00: if (HAS_COUNTERS) mcycle   <= new_val;
                  12'hB02: if (HAS_COUNTERS) minstret <= new_val;
                  default: ;
                endcase
              end
            end else begin
              rd_w_q <= bus.rd_w;
            end
          end
        end
        S_RESP: begin
          if (bus.out_ready) begin
            state       <= S_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready      = in_ready_q;
  assign bus.out_valid     = out_valid_q;
  assign bus.rd_o          = rd_q;
  assign bus.rd_a_o        = rd_a_q;
  assign bus.rd_w_o        = rd_w_q;
  assign bus.redirect      = redirect_q;
  assign bus.redirect_addr = redirect_addr_q;
endmodule

// File: tb/tb_csr_unit_v2.sv
// Bench for csr_unit_v2: directed scenarios plus randomized requests against a
// per-request architectural model of the machine-mode CSR state.
module tb_csr_unit_v2;
  localparam int unsigned XLEN = 64;
  typedef logic [XLEN-1:0] word_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic retire = 1'b0;
  logic irq_timer = 1'b0;

  csr_unit_v2_if #(.XLEN(XLEN)) bus ();

  csr_unit_v2 #(
    .XLEN(XLEN),
    .MSTATUS_RST(64'ha00001800),
    .MTVEC_RST(64'h0),
    .HAS_COUNTERS(1'b1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .retire(retire),
    .irq_timer(irq_timer),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  word_t m_mstatus, m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mcycle, m_minstret;

  task automatic check(input string tag, input word_t got, input word_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock edge; counters advance in the model whenever reset is released.
  task automatic tick();
    retire = 1'($urandom_range(0, 1));
    @(posedge clk);
    if (rst_n) begin
      m_mcycle += 1;
      if (retire) m_minstret += 1;
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    m_mstatus = 64'ha00001800;
    m_mtvec = '0;
    m_mie = '0; m_mscratch = '0; m_mepc = '0; m_mcause = '0;
    m_mcycle = '0; m_minstret = '0;
    rst_n = 1'b1;
  endtask

  task automatic check_reset_outputs();
    check("rst_in_ready", word_t'(bus.in_ready), 64'd1);
    check("rst_out_valid", word_t'(bus.out_valid), 64'd0);
    check("rst_redirect", word_t'(bus.redirect), 64'd0);
    check("rst_rd_w_o", word_t'(bus.rd_w_o), 64'd0);
    check("rst_rd_o", bus.rd_o, 64'd0);
    check("rst_rd_a_o", word_t'(bus.rd_a_o), 64'd0);
    check("rst_redirect_addr", bus.redirect_addr, 64'd0);
  endtask

  // Issue one request, update the model, check the response and its hold behaviour.
  task automatic req(input logic [2:0] op, input logic [2:0] f3, input logic [11:0] addr,
                     input word_t rs1, input logic [4:0] zi, input word_t pc,
                     input logic [4:0] rda, input logic rdw, input int unsigned hold,
                     output word_t got_rd);
    word_t old, src, nv, e_rd, e_ra, cause, pre_mtvec, pre_mepc;
    logic e_rdw, e_red, known, ro, wr, ill, irq, trap, pre_mie, pre_mpie;
    check("in_ready", word_t'(bus.in_ready), 64'd1);
    bus.op = op; bus.func3 = f3; bus.csr_addr = addr; bus.rs1_val = rs1;
    bus.zimm = zi; bus.pc = pc; bus.rd_a = rda; bus.rd_w = rdw;
    bus.in_valid = 1'b1;

    src = f3[2] ? word_t'(zi) : rs1;
    known = 1'b1; ro = 1'b0; old = '0;
    case (addr)
      12'h300: old = m_mstatus;
      12'h304: old = m_mie;
      12'h305: old = m_mtvec;
      12'h340: old = m_mscratch;
      12'h341: old = m_mepc;
      12'h342: old = m_mcause;
      12'h344: begin old = irq_timer ? 64'h80 : 64'h0; ro = 1'b1; end
      12'hB00: old = m_mcycle;
      12'hB02: old = m_minstret;
      default: known = 1'b0;
    endcase
    wr = (f3[1:0] == 2'b01) || (src != 0);
    ill = (op > 3'd4) || (op == 3'd1 && (!known || f3[1:0] == 2'b00 || (wr && ro)));
    irq = m_mstatus[3] && m_mie[7] && irq_timer;
    trap = irq || ill || op == 3'd2 || op == 3'd3;
    cause = irq ? {1'b1, 63'd7} : ill ? 64'd2 : (op == 3'd2) ? 64'd11 : 64'd3;
    case (f3[1:0])
      2'b01:   nv = src;
      2'b10:   nv = old | src;
      default: nv = old & ~src;
    endcase
    pre_mtvec = m_mtvec; pre_mepc = m_mepc;
    pre_mie = m_mstatus[3]; pre_mpie = m_mstatus[7];
    e_rd = '0; e_rdw = 1'b0; e_red = 1'b0; e_ra = '0;

    tick();
    bus.in_valid = 1'b0;

    if (trap) begin
      m_mepc = {pc[63:2], 2'b00};
      m_mcause = cause;
      m_mstatus[7] = pre_mie;
      m_mstatus[3] = 1'b0;
      m_mstatus[12:11] = 2'b11;
      e_red = 1'b1; e_ra = pre_mtvec;
    end else if (op == 3'd4) begin
      m_mstatus[3] = pre_mpie;
      m_mstatus[7] = 1'b1;
      e_red = 1'b1; e_ra = pre_mepc;
    end else if (op == 3'd1) begin
      e_rd = old; e_rdw = rdw;
      if (wr) begin
        case (addr)
          12'h300: m_mstatus = nv;
          12'h304: m_mie = nv & 64'h80;
          12'h305: m_mtvec = nv & ~64'h3;
          12'h340: m_mscratch = nv;
          12'h341: m_mepc = nv & ~64'h3;
          12'h342: m_mcause = nv;
          12'hB00: m_mcycle = nv;
          12'hB02: m_minstret = nv;
          default: ;
        endcase
      end
    end else begin
      e_rdw = rdw;
    end

    got_rd = bus.rd_o;
    check("out_valid", word_t'(bus.out_valid), 64'd1);
    check("rd_o", bus.rd_o, e_rd);
    check("rd_a_o", word_t'(bus.rd_a_o), word_t'(rda));
    check("rd_w_o", word_t'(bus.rd_w_o), word_t'(e_rdw));
    check("redirect", word_t'(bus.redirect), word_t'(e_red));
    if (e_red) check("redirect_addr", bus.redirect_addr, e_ra);

    bus.out_ready = 1'b0;
    for (int unsigned h = 0; h < hold; h++) begin
      tick();
      check("hold_out_valid", word_t'(bus.out_valid), 64'd1);
      check("hold_in_ready", word_t'(bus.in_ready), 64'd0);
      check("hold_rd_o", bus.rd_o, e_rd);
      check("hold_redirect", word_t'(bus.redirect), word_t'(e_red));
      if (e_red) check("hold_redirect_addr", bus.redirect_addr, e_ra);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("release_out_valid", word_t'(bus.out_valid), 64'd0);
  endtask

  task automatic rd_csr(input logic [11:0] addr, output word_t v);
    req(3'd1, 3'b010, addr, '0, 5'd0, 64'h1000, 5'd1, 1'b1, 0, v);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    word_t v;
    logic [11:0] addrs [11] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                                12'h344, 12'hB00, 12'hB02, 12'h7C0, 12'hF14};
    logic [2:0] opv;
    word_t rs1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.op = '0; bus.func3 = '0;
    bus.csr_addr = '0; bus.rs1_val = '0; bus.zimm = '0; bus.pc = '0;
    bus.rd_a = '0; bus.rd_w = 1'b0;

    do_reset();
    check_reset_outputs();

    req(3'd1, 3'b001, 12'h305, 64'h8000_0003, 5'd0, 64'h10, 5'd5, 1'b1, 0, v);
    check("mtvec_old", v, 64'h0);
    rd_csr(12'h305, v);
    check("mtvec_masked", v, 64'h8000_0000);

    rd_csr(12'h300, v);
    check("mstatus_rst", v, 64'ha00001800);
    req(3'd1, 3'b110, 12'h300, '0, 5'd8, 64'h14, 5'd2, 1'b1, 0, v);
    rd_csr(12'h300, v);
    check("mstatus_mie_set", v, 64'ha00001808);

    req(3'd1, 3'b001, 12'h305, 64'h100, 5'd0, 64'h18, 5'd0, 1'b0, 0, v);
    req(3'd2, 3'b000, 12'h000, '0, 5'd0, 64'h40, 5'd3, 1'b1, 1, v);
    rd_csr(12'h341, v);
    check("ecall_mepc", v, 64'h40);
    rd_csr(12'h342, v);
    check("ecall_mcause", v, 64'd11);
    rd_csr(12'h300, v);
    check("ecall_mstatus", v, 64'ha00001880);

    req(3'd4, 3'b000, 12'h000, '0, 5'd0, 64'h80, 5'd0, 1'b0, 3, v);
    rd_csr(12'h300, v);
    check("mret_mstatus", v, 64'ha00001888);

    req(3'd1, 3'b001, 12'h304, '1, 5'd0, 64'h1c, 5'd0, 1'b0, 0, v);
    rd_csr(12'h304, v);
    check("mie_mask", v, 64'h80);
    irq_timer = 1'b1;
    req(3'd1, 3'b001, 12'h340, 64'h55, 5'd0, 64'h200, 5'd7, 1'b1, 0, v);
    irq_timer = 1'b0;
    rd_csr(12'h342, v);
    check("irq_mcause", v, 64'h8000_0000_0000_0007);
    rd_csr(12'h340, v);
    check("irq_not_executed", v, 64'h0);
    rd_csr(12'h341, v);
    check("irq_mepc", v, 64'h200);

    req(3'd1, 3'b001, 12'hB00, '1, 5'd0, 64'h20, 5'd0, 1'b0, 0, v);
    rd_csr(12'hB00, v);
    check("mcycle_wrap", v, 64'h0);

    req(3'd1, 3'b001, 12'h7C0, 64'h5, 5'd0, 64'h24, 5'd4, 1'b1, 0, v);
    rd_csr(12'h342, v);
    check("illegal_mcause", v, 64'd2);

    // Reset while the response is pending discards it and the write it carried.
    bus.op = 3'd1; bus.func3 = 3'b001; bus.csr_addr = 12'h340; bus.rs1_val = 64'h1234;
    bus.pc = 64'h28; bus.rd_a = 5'd9; bus.rd_w = 1'b1; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    check("pre_reset_out_valid", word_t'(bus.out_valid), 64'd1);
    do_reset();
    check_reset_outputs();
    rd_csr(12'h340, v);
    check("reset_drops_write", v, 64'h0);

    for (int unsigned i = 0; i < 250; i++) begin
      case ($urandom_range(0, 9))
        6: opv = 3'd2;
        7: opv = 3'd3;
        8: opv = 3'd4;
        9: opv = 3'($urandom_range(0, 7));
        default: opv = 3'd1;
      endcase
      rs1 = ($urandom_range(0, 3) == 0) ? '0 : {32'($urandom), 32'($urandom)};
      irq_timer = 1'($urandom_range(0, 1));
      req(opv, 3'($urandom_range(0, 7)), addrs[$urandom_range(0, 10)], rs1,
          ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom), {32'($urandom), 30'($urandom), 2'b00},
          5'($urandom), 1'($urandom), $urandom_range(0, 2), v);
    end
    irq_timer = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
